// File: rtl/cache_pkg.sv
// Shared types and defaults for the memory-side cache blocks.
package cache_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_WORDS  = 4;

  typedef enum logic [1:0] {
    IDLE,
    WB_XFER,
    FILL_XFER,
    DONE
  } mem_adapt_state_t;

  // Byte-offset width of a line: word index bits plus byte-within-word bits.
  function automatic int off_w(input int words, input int data_w);
    return $clog2(words) + $clog2(data_w / 8);
  endfunction
endpackage

// File: rtl/cache_line_buf.sv
// WORDS x DATA_W line register file: parallel line load, indexed word write/read, flat line view.
module cache_line_buf
  import cache_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int WORDS  = DEF_WORDS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load,
  input  logic [WORDS*DATA_W-1:0]    load_line,
  input  logic                       wr_en,
  input  logic [$clog2(WORDS)-1:0]   wr_idx,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [$clog2(WORDS)-1:0]   rd_idx,
  output logic [DATA_W-1:0]          rd_data,
  output logic [WORDS*DATA_W-1:0]    line
);
  logic [DATA_W-1:0] mem_q [WORDS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS; i++) mem_q[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < WORDS; i++) mem_q[i] <= load_line[i*DATA_W +: DATA_W];
    end else if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_idx];

  for (genvar g = 0; g < WORDS; g++) begin : g_flat
    assign line[g*DATA_W +: DATA_W] = mem_q[g];
  end
endmodule

// File: rtl/cache_mem_adapter.sv
// Burst engine: line-level fill/write-back requests become WORDS single-word memory transactions.
// Optional per-word wait timeout with abort is enabled by defining CACHE_MEM_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | waiting for mem_write (priority) or mem_read
// WB_XFER   | writing the latched line to memory, one word per mm_ack
// FILL_XFER | reading line words from memory into the buffer
// DONE      | one-cycle gap, requests ignored; fill_valid pulses here after a full fill
module cache_mem_adapter
  import cache_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int WORDS   = DEF_WORDS,
  parameter int TIMEOUT = 256
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  mem_read,
  input  logic                                  mem_write,
  input  logic [ADDR_W-off_w(WORDS,DATA_W)-1:0] line_addr,
  input  logic [WORDS*DATA_W-1:0]               wb_line,
  output logic                                  ca_resp,
  output logic [WORDS*DATA_W-1:0]               fill_line,
  output logic                                  fill_valid,
  output logic                                  error,
  output logic                                  mm_req,
  output logic                                  mm_we,
  output logic [ADDR_W-1:0]                     mm_addr,
  output logic [DATA_W-1:0]                     mm_wdata,
  input  logic [DATA_W-1:0]                     mm_rdata,
  input  logic                                  mm_ack
);
  localparam int OFF_W  = off_w(WORDS, DATA_W);
  localparam int WIDX_W = $clog2(WORDS);
  localparam int BYTE_W = $clog2(DATA_W / 8);
  localparam int LINE_W = WORDS * DATA_W;
  localparam int LA_W   = ADDR_W - OFF_W;

  mem_adapt_state_t state_q, state_d;
  logic [LA_W-1:0]   addr_q;
  logic [WIDX_W-1:0] widx_q;
  logic [LINE_W-1:0] fill_line_q, buf_line, merged_line;
  logic              fill_valid_q;
  logic              accept_wb, accept_rd, accept, xfer, last_ack, abort;

  assign xfer     = (state_q == WB_XFER) || (state_q == FILL_XFER);
  assign accept   = accept_wb || accept_rd;
  assign last_ack = xfer && mm_ack && (widx_q == WIDX_W'(WORDS - 1));

  always_comb begin
    state_d   = state_q;
    accept_wb = 1'b0;
    accept_rd = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_write) begin
          accept_wb = 1'b1;
          state_d   = WB_XFER;
        end else if (mem_read) begin
          accept_rd = 1'b1;
          state_d   = FILL_XFER;
        end
      end
      WB_XFER, FILL_XFER: if (last_ack || abort) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The final word bypasses the buffer so fill_line is complete in the DONE cycle.
  always_comb begin
    merged_line = buf_line;
    merged_line[widx_q*DATA_W +: DATA_W] = mm_rdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      widx_q       <= '0;
      fill_line_q  <= '0;
      fill_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_valid_q <= 1'b0;
      if (accept) begin
        addr_q <= line_addr;
        widx_q <= '0;
      end else if (xfer && mm_ack) begin
        widx_q <= widx_q + 1'b1;
      end
      if (state_q == FILL_XFER && last_ack) begin
        fill_line_q  <= merged_line;
        fill_valid_q <= 1'b1;
      end
    end
  end

  cache_line_buf #(.DATA_W(DATA_W), .WORDS(WORDS)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept_wb),
    .load_line (wb_line),
    .wr_en     ((state_q == FILL_XFER) && mm_ack),
    .wr_idx    (widx_q),
    .wr_data   (mm_rdata),
    .rd_idx    (widx_q),
    .rd_data   (mm_wdata),
    .line      (buf_line)
  );

`ifdef CACHE_MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT);
  logic [CNT_W-1:0] wait_q;
  logic             error_q;

  assign abort = xfer && !mm_ack && (wait_q == CNT_W'(TIMEOUT - 1));
  assign error = error_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_q  <= '0;
      error_q <= 1'b0;
    end else begin
      if (accept)    wait_q <= '0;
      else if (xfer) wait_q <= mm_ack ? '0 : wait_q + 1'b1;
      if (accept)     error_q <= 1'b0;
      else if (abort) error_q <= 1'b1;
    end
  end
`else
  assign abort = 1'b0;
  // Always 0 here; the compare keeps TIMEOUT referenced in both builds.
  assign error = (TIMEOUT < 0);
`endif

  assign ca_resp    = xfer;
  assign mm_req     = xfer;
  assign mm_we      = (state_q == WB_XFER);
  assign mm_addr    = {addr_q, widx_q, {BYTE_W{1'b0}}};
  assign fill_line  = fill_line_q;
  assign fill_valid = fill_valid_q;
endmodule

// File: tb/tb_cache_mem_adapter.sv
// Scoreboard bench for cache_mem_adapter; timeout checks follow CACHE_MEM_TIMEOUT_EN.
module tb_cache_mem_adapter;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int WORDS   = 4;
  localparam int TIMEOUT = 8;
  localparam int LINE_W  = WORDS * DATA_W;
  localparam int LA_W    = ADDR_W - 4;

  logic              clk = 1'b0;
  logic              rst_n, mem_read, mem_write;
  logic [LA_W-1:0]   line_addr;
  logic [LINE_W-1:0] wb_line, fill_line;
  logic              ca_resp, fill_valid, error, mm_req, mm_we;
  logic              mm_ack = 1'b0;
  logic [ADDR_W-1:0] mm_addr;
  logic [DATA_W-1:0] mm_wdata;
  logic [DATA_W-1:0] mm_rdata = '0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] wdata;
  } txn_t;

  txn_t              exp_q[$];
  logic [LINE_W-1:0] fill_q[$];
  int total = 0, bad = 0;
  int req_cycles = 0, resp_cycles = 0, fill_pulses = 0, wcnt = 0, wait_cfg = 0;
  logic              ack_en = 1'b1;
  logic [DATA_W-1:0] rd_base = '0;

  always #5 clk = ~clk;

  cache_mem_adapter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WORDS(WORDS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .line_addr(line_addr), .wb_line(wb_line), .ca_resp(ca_resp), .fill_line(fill_line),
    .fill_valid(fill_valid), .error(error), .mm_req(mm_req), .mm_we(mm_we),
    .mm_addr(mm_addr), .mm_wdata(mm_wdata), .mm_rdata(mm_rdata), .mm_ack(mm_ack)
  );

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] line_of(input logic [DATA_W-1:0] b);
    logic [LINE_W-1:0] l;
    for (int i = 0; i < WORDS; i++) l[i*DATA_W +: DATA_W] = b + DATA_W'(i);
    return l;
  endfunction

  task automatic push_burst(input logic [LA_W-1:0] la, input logic we, input logic [LINE_W-1:0] line);
    for (int i = 0; i < WORDS; i++) begin
      txn_t t;
      t.addr  = {la, 4'h0} + ADDR_W'(4 * i);
      t.we    = we;
      t.wdata = line[i*DATA_W +: DATA_W];
      exp_q.push_back(t);
    end
  endtask

  // Returns the negedge index (counted from the call) of the DONE cycle.
  task automatic wait_done(output int n);
    bit seen = 0, done = 0;
    n = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      n++;
      if (ca_resp) seen = 1;
      else if (seen) done = 1;
    end
    chk("burst_bound", 128'(done), 128'(1));
  endtask

  task automatic check_zero(input string p);
    chk({p, "_mm_req"},     128'(mm_req),     128'(0));
    chk({p, "_ca_resp"},    128'(ca_resp),    128'(0));
    chk({p, "_mm_we"},      128'(mm_we),      128'(0));
    chk({p, "_mm_addr"},    128'(mm_addr),    128'(0));
    chk({p, "_mm_wdata"},   128'(mm_wdata),   128'(0));
    chk({p, "_fill_line"},  128'(fill_line),  128'(0));
    chk({p, "_fill_valid"}, 128'(fill_valid), 128'(0));
    chk({p, "_error"},      128'(error),      128'(0));
  endtask

  // Memory responder plus scoreboard: acks are decided and checked on the falling edge.
  always @(negedge clk) begin
    if (rst_n && mm_req) begin
      req_cycles++;
      if (ack_en && wcnt >= wait_cfg) begin
        mm_ack   = 1'b1;
        mm_rdata = rd_base + DATA_W'(mm_addr[3:2]);
        wcnt     = 0;
        chk("txn_pending", 128'(exp_q.size() != 0), 128'(1));
        if (exp_q.size() != 0) begin
          txn_t e;
          e = exp_q.pop_front();
          chk("mm_addr", 128'(mm_addr), 128'(e.addr));
          chk("mm_we", 128'(mm_we), 128'(e.we));
          if (e.we) chk("mm_wdata", 128'(mm_wdata), 128'(e.wdata));
        end
      end else begin
        mm_ack = 1'b0;
        wcnt++;
        if (exp_q.size() != 0) begin
          chk("hold_addr", 128'(mm_addr), 128'(exp_q[0].addr));
          if (exp_q[0].we) chk("hold_wdata", 128'(mm_wdata), 128'(exp_q[0].wdata));
        end
      end
    end else begin
      mm_ack = 1'b0;
      wcnt   = 0;
    end
    if (ca_resp) resp_cycles++;
    if (fill_valid) begin
      fill_pulses++;
      chk("fill_pending", 128'(fill_q.size() != 0), 128'(1));
      if (fill_q.size() != 0) chk("fill_line", fill_line, fill_q.pop_front());
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, pf;
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; line_addr = '0; wb_line = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("rst");
    @(posedge clk); #1 rst_n = 1'b1;

    // Zero-wait fill
    @(posedge clk); #1;
    rd_base = 32'hA0; wait_cfg = 0; resp_cycles = 0;
    push_burst(28'h0000100, 1'b0, '0);
    fill_q.push_back(line_of(32'hA0));
    mem_read = 1'b1; line_addr = 28'h0000100;
    @(posedge clk); #1 mem_read = 1'b0; line_addr = '0;
    wait_done(n);
    chk("fill_done_cycle", 128'(n), 128'(WORDS + 1));
    chk("fill_pulse", 128'(fill_valid), 128'(1));
    chk("fill_data", fill_line, 128'h000000A3_000000A2_000000A1_000000A0);
    @(negedge clk);
    chk("fill_resp_cycles", 128'(resp_cycles), 128'(WORDS));
    chk("fill_idle_valid", 128'(fill_valid), 128'(0));
    chk("fill_idle_resp", 128'(ca_resp), 128'(0));

    // Write-back, two wait cycles per word
    @(posedge clk); #1;
    wait_cfg = 2; resp_cycles = 0; pf = fill_pulses;
    push_burst(28'h0000200, 1'b1, 128'h000000D3_000000D2_000000D1_000000D0);
    wb_line = 128'h000000D3_000000D2_000000D1_000000D0;
    mem_write = 1'b1; line_addr = 28'h0000200;
    @(posedge clk); #1 mem_write = 1'b0; wb_line = '1; line_addr = '1;
    wait_done(n);
    chk("wb_done_cycle", 128'(n), 128'(13));
    @(negedge clk);
    chk("wb_resp_cycles", 128'(resp_cycles), 128'(12));
    chk("wb_no_fill", 128'(fill_pulses), 128'(pf));
    chk("wb_drained", 128'(exp_q.size()), 128'(0));

    // Simultaneous read and write: write first
    @(posedge clk); #1;
    wait_cfg = 0; resp_cycles = 0; pf = fill_pulses; rd_base = 32'hB0;
    push_burst(28'h0000300, 1'b1, line_of(32'h5A0));
    push_burst(28'h0000300, 1'b0, '0);
    fill_q.push_back(line_of(32'hB0));
    wb_line = line_of(32'h5A0); line_addr = 28'h0000300;
    mem_read = 1'b1; mem_write = 1'b1;
    @(posedge clk);
    wait_done(n);
    chk("sim_wb_done", 128'(n), 128'(WORDS + 1));
    mem_write = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 mem_read = 1'b0;
    wait_done(n);
    chk("sim_rd_done", 128'(n), 128'(WORDS + 1));
    @(negedge clk);
    chk("sim_fill_once", 128'(fill_pulses), 128'(pf + 1));
    chk("sim_resp_cycles", 128'(resp_cycles), 128'(2 * WORDS));
    chk("sim_drained", 128'(exp_q.size()), 128'(0));

    // Reset after the ack of word 1
    @(posedge clk); #1;
    pf = fill_pulses;
    push_burst(28'h0000400, 1'b0, '0);
    mem_read = 1'b1; line_addr = 28'h0000400;
    @(posedge clk); #1 mem_read = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_zero("midrst");
    chk("midrst_words_left", 128'(exp_q.size()), 128'(2));
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    chk("midrst_no_fill", 128'(fill_pulses), 128'(pf));
    rd_base = 32'hC0;
    push_burst(28'h0000500, 1'b0, '0);
    fill_q.push_back(line_of(32'hC0));
    mem_read = 1'b1; line_addr = 28'h0000500;
    @(posedge clk); #1 mem_read = 1'b0;
    wait_done(n);
    chk("restart_done", 128'(n), 128'(WORDS + 1));
    @(negedge clk);
    chk("restart_fill", 128'(fill_pulses), 128'(pf + 1));
    chk("restart_drained", 128'(exp_q.size()), 128'(0));

    // Memory never acks
    @(posedge clk); #1;
    ack_en = 1'b0; pf = fill_pulses;
    mem_read = 1'b1; line_addr = 28'h0000600;
    @(posedge clk); #1 mem_read = 1'b0; req_cycles = 0;
    repeat (30) @(negedge clk);
    #1;
`ifdef CACHE_MEM_TIMEOUT_EN
    chk("to_req_cycles", 128'(req_cycles), 128'(TIMEOUT));
    chk("to_error", 128'(error), 128'(1));
    chk("to_mm_req", 128'(mm_req), 128'(0));
    chk("to_ca_resp", 128'(ca_resp), 128'(0));
    chk("to_no_fill", 128'(fill_pulses), 128'(pf));
    chk("to_line_kept", fill_line, line_of(32'hC0));
    ack_en = 1'b1;
    @(posedge clk); #1;
    rd_base = 32'hE0;
    push_burst(28'h0000700, 1'b0, '0);
    fill_q.push_back(line_of(32'hE0));
    mem_read = 1'b1; line_addr = 28'h0000700;
    @(posedge clk); #1 mem_read = 1'b0;
    @(negedge clk);
    chk("to_error_cleared", 128'(error), 128'(0));
    wait_done(n);
    @(negedge clk);
    chk("to_next_fill", 128'(fill_pulses), 128'(pf + 1));
`else
    chk("stall_mm_req", 128'(mm_req), 128'(1));
    chk("stall_req_cycles", 128'(req_cycles), 128'(30));
    chk("stall_error", 128'(error), 128'(0));
    chk("stall_ca_resp", 128'(ca_resp), 128'(1));
    rd_base = 32'hF0;
    push_burst(28'h0000600, 1'b0, '0);
    fill_q.push_back(line_of(32'hF0));
    ack_en = 1'b1;
    wait_done(n);
    @(negedge clk);
    chk("stall_fill", 128'(fill_pulses), 128'(pf + 1));
`endif
    chk("end_txn_queue", 128'(exp_q.size()), 128'(0));
    chk("end_fill_queue", 128'(fill_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
